// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline stage: aligns loads, selects the write-back source,
// drives the register-file write port and bypasses the in-flight write to decode.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          MValid,
    input  logic          MRegWrite,
    input  logic [1:0]    MWbSel,
    input  logic [AW-1:0] MRDest,
    input  logic [DW-1:0] MAluRes,
    input  logic [DW-1:0] MMemData,
    input  logic [DW-1:0] MLink,
    input  logic [1:0]    MSize,
    input  logic          MSigned,
    input  logic [1:0]    MAddrLo,
    output logic          WEn,
    output logic [AW-1:0] RDest,
    output logic [DW-1:0] WData,
    input  logic [AW-1:0] RInA,
    input  logic [AW-1:0] RInB,
    input  logic [DW-1:0] OutA,
    input  logic [DW-1:0] OutB,
    output logic [DW-1:0] FwdA,
    output logic [DW-1:0] FwdB,
    output logic [31:0]   RetireCnt
);

    logic          valid_q;
    logic          regwrite_q;
    logic [AW-1:0] rdest_q;
    logic [DW-1:0] wdata_q;
    logic [31:0]   retire_cnt_q;
    logic [31:0]   retire_cnt_d;
    logic [DW-1:0] wb_data_s;
    logic          capture_s;

    // Little-endian sub-word extraction; half-word selection ignores address bit 0.
    function automatic logic [DW-1:0] align_load(
        input logic [DW-1:0] word,
        input logic [1:0]    size,
        input logic          sgn,
        input logic [1:0]    lo
    );
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        b = 8'd0;
        h = 16'd0;
        r = word;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        if (lo[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b01:   r = {{(DW-16){sgn & h[15]}}, h};
            2'b10:   r = {{(DW-8){sgn & b[7]}}, b};
            default: r = word;
        endcase
        return r;
    endfunction

    // Write-back source select, fully formed before capture.
    always_comb begin
        wb_data_s = MAluRes;
        case (MWbSel)
            2'b01:   wb_data_s = align_load(MMemData, MSize, MSigned, MAddrLo);
            2'b10:   wb_data_s = MLink;
            default: wb_data_s = MAluRes;
        endcase
    end

    assign capture_s = ~Flush & ~Stall;

    // Retired-instruction counter next state; wraps modulo 2^32.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (capture_s && MValid) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Stage register: reset, then flush bubble, then stall hold, then capture.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            rdest_q      <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            retire_cnt_q <= 32'd0;
        end else if (Flush) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            rdest_q      <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
        end else if (!Stall) begin
            valid_q      <= MValid;
            regwrite_q   <= MRegWrite & MValid;
            rdest_q      <= MRDest;
            wdata_q      <= wb_data_s;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // R0 is hard-wired to zero, so writes to it never leave the stage.
    assign WEn       = valid_q & regwrite_q & (rdest_q != {AW{1'b0}});
    assign RDest     = rdest_q;
    assign WData     = wdata_q;
    assign RetireCnt = retire_cnt_q;

    // Bypass the pending write so decode sees it before the register file commits.
    always_comb begin
        FwdA = OutA;
        FwdB = OutB;
        if (WEn && (RInA == rdest_q)) begin
            FwdA = wdata_q;
        end else begin
            FwdA = OutA;
        end
        if (WEn && (RInB == rdest_q)) begin
            FwdB = wdata_q;
        end else begin
            FwdB = OutB;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: one task per scenario.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RSTn, Stall, Flush, MValid, MRegWrite, MSigned;
    logic [1:0]  MWbSel, MSize, MAddrLo;
    logic [3:0]  MRDest, RDest, RInA, RInB;
    logic [31:0] MAluRes, MMemData, MLink, WData, OutA, OutB, FwdA, FwdB, RetireCnt;
    logic        WEn;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt = 32'd0;

    mem_wb_stage #(.DW(32), .AW(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .Flush(Flush),
        .MValid(MValid), .MRegWrite(MRegWrite), .MWbSel(MWbSel), .MRDest(MRDest),
        .MAluRes(MAluRes), .MMemData(MMemData), .MLink(MLink), .MSize(MSize),
        .MSigned(MSigned), .MAddrLo(MAddrLo), .WEn(WEn), .RDest(RDest), .WData(WData),
        .RInA(RInA), .RInB(RInB), .OutA(OutA), .OutB(OutB), .FwdA(FwdA), .FwdB(FwdB),
        .RetireCnt(RetireCnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] rd, input logic [31:0] val);
        MValid = 1'b1; MRegWrite = 1'b1; MWbSel = 2'b00; MRDest = rd; MAluRes = val;
    endtask

    task automatic test_reset;
        RSTn = 1'b0; Stall = 1'b0; Flush = 1'b0; MValid = 1'b1; MRegWrite = 1'b1;
        MWbSel = 2'b00; MRDest = 4'd9; MAluRes = 32'hDEAD_BEEF; MMemData = 32'd0;
        MLink = 32'd0; MSize = 2'b00; MSigned = 1'b0; MAddrLo = 2'd0;
        RInA = 4'd0; RInB = 4'd9; OutA = 32'h1234; OutB = 32'h5678;
        tick(); tick();
        n_checks++; if (WEn !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", WEn); end
        n_checks++; if (RDest !== 4'd0) begin n_fail++; $display("FAIL reset_rdest got %h exp 0", RDest); end
        n_checks++; if (WData !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", WData); end
        n_checks++; if (RetireCnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", RetireCnt); end
        n_checks++; if (FwdB !== 32'h5678) begin n_fail++; $display("FAIL reset_fwdb got %h exp 5678", FwdB); end
    endtask

    task automatic test_alu_write;
        RSTn = 1'b1;
        drive_alu(4'd2, 32'd7);
        tick(); exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (WEn !== 1'b1) begin n_fail++; $display("FAIL alu_wen got %b exp 1", WEn); end
        n_checks++; if (RDest !== 4'd2) begin n_fail++; $display("FAIL alu_rdest got %h exp 2", RDest); end
        n_checks++; if (WData !== 32'd7) begin n_fail++; $display("FAIL alu_wdata got %h exp 7", WData); end
        n_checks++; if (RetireCnt !== 32'd1) begin n_fail++; $display("FAIL alu_cnt got %h exp 1", RetireCnt); end
    endtask

    task automatic test_load;
        logic [1:0]  sz  [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        sg  [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [1:0]  lo  [6] = '{2'd2,  2'd2,  2'd2,  2'd1,  2'd3,  2'd3};
        logic [31:0] mem [6] = '{32'h1280_3456, 32'h1280_3456, 32'h1280_9456,
                                 32'h1280_9456, 32'h1280_9456, 32'h1280_9456};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280,
                                 32'hFFFF_9456, 32'h1280_9456, 32'h0000_0012};
        for (int i = 0; i < 6; i++) begin
            MValid = 1'b1; MRegWrite = 1'b1; MWbSel = 2'b01; MRDest = 4'd5;
            MAluRes = 32'hAAAA_AAAA; MSize = sz[i]; MSigned = sg[i]; MAddrLo = lo[i];
            MMemData = mem[i];
            tick(); exp_cnt = exp_cnt + 32'd1;
            n_checks++;
            if (WData !== exp[i]) begin
                n_fail++; $display("FAIL load_%0d got %h exp %h", i, WData, exp[i]);
            end
        end
        n_checks++; if (RetireCnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt got %h exp %h", RetireCnt, exp_cnt); end
    endtask

    task automatic test_r0_fwd;
        drive_alu(4'd0, 32'd5);
        tick(); exp_cnt = exp_cnt + 32'd1;
        RInA = 4'd0; OutA = 32'h11; #1;
        n_checks++; if (WEn !== 1'b0) begin n_fail++; $display("FAIL r0_wen got %b exp 0", WEn); end
        n_checks++; if (FwdA !== 32'h11) begin n_fail++; $display("FAIL r0_fwda got %h exp 11", FwdA); end
        drive_alu(4'd3, 32'd9);
        tick(); exp_cnt = exp_cnt + 32'd1;
        RInA = 4'd3; OutA = 32'd1; RInB = 4'd4; OutB = 32'd6; #1;
        n_checks++; if (FwdA !== 32'd9) begin n_fail++; $display("FAIL fwd_a got %h exp 9", FwdA); end
        n_checks++; if (FwdB !== 32'd6) begin n_fail++; $display("FAIL fwd_b got %h exp 6", FwdB); end
        RInB = 4'd3; #1;
        n_checks++; if (FwdB !== 32'd9) begin n_fail++; $display("FAIL fwd_b_hit got %h exp 9", FwdB); end
        MRegWrite = 1'b0;
        tick(); exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (WEn !== 1'b0) begin n_fail++; $display("FAIL noregwr_wen got %b exp 0", WEn); end
        n_checks++; if (FwdB !== 32'd6) begin n_fail++; $display("FAIL noregwr_fwdb got %h exp 6", FwdB); end
        n_checks++; if (RetireCnt !== exp_cnt) begin n_fail++; $display("FAIL r0_cnt got %h exp %h", RetireCnt, exp_cnt); end
    endtask

    task automatic test_stall_flush;
        drive_alu(4'd5, 32'h55);
        tick(); exp_cnt = exp_cnt + 32'd1;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(4'(i + 7), 32'h100 + 32'(i));
            tick();
            n_checks++;
            if (WEn !== 1'b1 || RDest !== 4'd5 || WData !== 32'h55 || RetireCnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL stall_%0d got wen=%b rd=%h wd=%h cnt=%h exp 1 5 55 %h",
                         i, WEn, RDest, WData, RetireCnt, exp_cnt);
            end
        end
        Flush = 1'b1;
        tick();
        n_checks++; if (WEn !== 1'b0) begin n_fail++; $display("FAIL flush_wen got %b exp 0", WEn); end
        n_checks++; if (WData !== 32'd0) begin n_fail++; $display("FAIL flush_wdata got %h exp 0", WData); end
        n_checks++; if (RDest !== 4'd0) begin n_fail++; $display("FAIL flush_rdest got %h exp 0", RDest); end
        n_checks++; if (RetireCnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt got %h exp %h", RetireCnt, exp_cnt); end
        Stall = 1'b0;
        tick();
        n_checks++; if (RetireCnt !== exp_cnt || WEn !== 1'b0) begin n_fail++; $display("FAIL flush_only got cnt=%h wen=%b exp %h 0", RetireCnt, WEn, exp_cnt); end
        Flush = 1'b0; MValid = 1'b0;
        tick();
        n_checks++; if (RetireCnt !== exp_cnt || WEn !== 1'b0) begin n_fail++; $display("FAIL invalid got cnt=%h wen=%b exp %h 0", RetireCnt, WEn, exp_cnt); end
    endtask

    task automatic test_wrap;
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        n_checks++; if (RetireCnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL preload got %h exp ffffffff", RetireCnt); end
        MValid = 1'b1; MRegWrite = 1'b1; MWbSel = 2'b10; MRDest = 4'd15; MLink = 32'h40;
        tick();
        n_checks++; if (WData !== 32'h40) begin n_fail++; $display("FAIL link_wdata got %h exp 40", WData); end
        n_checks++; if (RDest !== 4'd15 || WEn !== 1'b1) begin n_fail++; $display("FAIL link_port got rd=%h wen=%b exp f 1", RDest, WEn); end
        n_checks++; if (RetireCnt !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt got %h exp 0", RetireCnt); end
    endtask

    task automatic test_async_reset;
        drive_alu(4'd6, 32'hAB);
        tick();
        n_checks++; if (WEn !== 1'b1 || RetireCnt !== 32'd1) begin n_fail++; $display("FAIL pre_rst got wen=%b cnt=%h exp 1 1", WEn, RetireCnt); end
        Stall = 1'b1;
        #2; RSTn = 1'b0; #1;
        n_checks++;
        if (WEn !== 1'b0 || RDest !== 4'd0 || WData !== 32'd0 || RetireCnt !== 32'd0) begin
            n_fail++;
            $display("FAIL async_rst got wen=%b rd=%h wd=%h cnt=%h exp all 0", WEn, RDest, WData, RetireCnt);
        end
        tick(); RSTn = 1'b1;
        tick();
        n_checks++; if (WEn !== 1'b0 || WData !== 32'd0 || RetireCnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall got wen=%b wd=%h cnt=%h exp 0 0 0", WEn, WData, RetireCnt); end
        Stall = 1'b0;
        tick();
        n_checks++; if (WData !== 32'hAB || RetireCnt !== 32'd1) begin n_fail++; $display("FAIL post_rst got wd=%h cnt=%h exp ab 1", WData, RetireCnt); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load();
        test_r0_fwd();
        test_stall_flush();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
